// File: rtl/pkg_Q3.sv
// Shared types for the ALSU command scheduler.
//   opcode_typedef : ALSU opcode encoding
//   alsu_in_t      : one cycle of ALSU input drive (everything except repeat count)
//   alsu_cmd_t     : a requester command = ALSU drive + repeat count
//   sched_state_t  : scheduler FSM states
//   PARK_CMD       : benign drive presented to the ALSU whenever no command is issuing
package pkg_Q3;

    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_typedef;

    typedef struct packed {
        opcode_typedef     opcode;
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              direction;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
    } alsu_in_t;

    typedef struct packed {
        alsu_in_t   alsu;
        logic [2:0] rpt;    // command is driven rpt+1 consecutive cycles
    } alsu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // OR of zeros: produces out=0, leds=0 and leaves no reduction/bypass side effects.
    localparam alsu_in_t PARK_CMD = '{
        opcode:    OR,
        A:         3'sd0,
        B:         3'sd0,
        cin:       1'b0,
        serial_in: 1'b0,
        direction: 1'b0,
        red_op_A:  1'b0,
        red_op_B:  1'b0,
        bypass_A:  1'b0,
        bypass_B:  1'b0
    };

endpackage

// File: rtl/alsu_rr_arb.sv
// Two-requester round-robin arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : grant allowed this cycle (scheduler idle)
//   req[1:0]  : request vector
//   ack       : the granted request was accepted this cycle
//   grant[1:0]: one-hot (or zero) grant
//   grant_idx : index of the granted requester
module alsu_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Index of the requester favoured on a tie: the one not granted last.
    logic ptr_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = req;   // zero or one bit set: the sole requester wins
            end
        end
    end

    assign grant_idx = grant[1];

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is written with non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (ack) begin
            ptr_q <= ~grant_idx;
        end
    end

endmodule

// File: rtl/alsu_sched.sv
// Arbitrates two command requesters onto a single registered ALSU, repeats the
// accepted command rpt+1 cycles, waits out the ALSU latency, then captures and
// presents the ALSU result on a valid/ready response port.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/ready/cmd : per-requester command handshake (2 requesters)
//   rsp_valid/ready     : response handshake
//   rsp_id/out/leds     : requester index and captured ALSU out/leds
//   alsu_*              : registered drive to the ALSU; alsu_rst is active-high
//   alsu_out/alsu_leds  : ALSU outputs
//   busy                : a command is in flight (state != IDLE)
module alsu_sched
    import pkg_Q3::*;
#(
    parameter int ALSU_LAT = 2     // must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  alsu_cmd_t [1:0]      req_cmd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic signed [5:0]    rsp_out,
    output logic [15:0]          rsp_leds,
    output opcode_typedef        alsu_opcode,
    output logic signed [2:0]    alsu_A,
    output logic signed [2:0]    alsu_B,
    output logic                 alsu_cin,
    output logic                 alsu_serial_in,
    output logic                 alsu_direction,
    output logic                 alsu_red_op_A,
    output logic                 alsu_red_op_B,
    output logic                 alsu_bypass_A,
    output logic                 alsu_bypass_B,
    output logic                 alsu_rst,
    input  logic signed [5:0]    alsu_out,
    input  logic [15:0]          alsu_leds,
    output logic                 busy
);

    // One counter serves both the ISSUE repeat count (up to 8) and DRAIN (ALSU_LAT).
    localparam int CNT_W = ($clog2(ALSU_LAT) > 3) ? $clog2(ALSU_LAT) : 3;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ALSU_LAT - 1);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rpt_q;
    logic             id_q;
    logic signed [5:0] rsp_out_q;
    logic [15:0]      rsp_leds_q;
    alsu_in_t         alsu_q;

    logic [1:0]       grant;
    logic             grant_idx;
    logic             accept;
    logic             capture;

    alsu_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == IDLE),
        .req       (req_valid),
        .ack       (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_W'(rpt_q)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // The last drain edge sees the ALSU output for the final issued cycle.
                if (cnt_q == DRAIN_LAST) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rpt_q      <= '0;
            id_q       <= 1'b0;
            rsp_out_q  <= '0;
            rsp_leds_q <= '0;
            alsu_q     <= PARK_CMD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rpt_q <= req_cmd[grant_idx].rpt;
                id_q  <= grant_idx;
            end
            if (capture) begin
                rsp_out_q  <= alsu_out;
                rsp_leds_q <= alsu_leds;
            end
            // The drive register is loaded at the accept edge so the command is
            // on the ALSU for exactly the cycles spent in ISSUE.
            if (state_d != ISSUE) begin
                alsu_q <= PARK_CMD;
            end else if (accept) begin
                alsu_q <= req_cmd[grant_idx].alsu;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_leds  = rsp_leds_q;

    assign alsu_opcode    = alsu_q.opcode;
    assign alsu_A         = alsu_q.A;
    assign alsu_B         = alsu_q.B;
    assign alsu_cin       = alsu_q.cin;
    assign alsu_serial_in = alsu_q.serial_in;
    assign alsu_direction = alsu_q.direction;
    assign alsu_red_op_A  = alsu_q.red_op_A;
    assign alsu_red_op_B  = alsu_q.red_op_B;
    assign alsu_bypass_A  = alsu_q.bypass_A;
    assign alsu_bypass_B  = alsu_q.bypass_B;
    assign alsu_rst       = ~rst;

endmodule
